// File: rtl/femb_pll_pkg.sv
// Shared types and sizing helpers for the FEMB PLL lock controller.
package femb_pll_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    READY     = 3'd3,
    FAULT     = 3'd4
  } pll_state_t;

  // Width of the saturating status counters.
  localparam int unsigned CNT_W = 16;

  // Bits needed by a down-counter that is loaded with (largest period - 1).
  function automatic int unsigned tmr_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/femb_pll_lock_ctrl.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for lock, settles, then
// reports ready; retries on timeout and parks in FAULT after MAX_RETRY misses.
module femb_pll_lock_ctrl
  import femb_pll_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 100000,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              req_reset,
  input  logic              clr_counts,
  output logic              pll_rst,
  output logic              ready,
  output logic              fault,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  unlock_count,
  output logic [CNT_W-1:0]  timeout_count
);

  localparam int unsigned TMR_W = tmr_width(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);

  localparam logic [TMR_W-1:0] LD_RST    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] LD_LOCK   = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LD_SETTLE = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_LAST  = RTY_W'(MAX_RETRY - 1);

  pll_state_t       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_load;
  logic [RTY_W-1:0] retry_q;
  logic [CNT_W-1:0] unlock_cnt, timeout_cnt;
  logic             lk, tmr_zero, reload, timeout, unlock;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  assign tmr_zero      = (tmr_q == '0);
  assign state         = state_q;
  assign unlock_count  = unlock_cnt;
  assign timeout_count = timeout_cnt;

  always_comb begin
    state_d  = state_q;
    timeout  = 1'b0;
    unlock   = 1'b0;
    tmr_load = '0;
    case (state_q)
      RESET_PLL: if (tmr_zero) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lk) begin
          state_d = SETTLE;
        end else if (tmr_zero) begin
          timeout = 1'b1;
          state_d = (retry_q >= RTY_LAST) ? FAULT : RESET_PLL;
        end
      end
      SETTLE: begin
        if (!lk)           state_d = WAIT_LOCK;
        else if (tmr_zero) state_d = READY;
      end
      READY: begin
        if (!lk) begin
          unlock  = 1'b1;
          state_d = RESET_PLL;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = RESET_PLL;
    endcase
    // Software restart overrides whatever the state logic decided this cycle.
    if (req_reset) begin
      state_d = RESET_PLL;
      timeout = 1'b0;
      unlock  = 1'b0;
    end
    reload = req_reset || (state_d != state_q);
    case (state_d)
      RESET_PLL: tmr_load = LD_RST;
      WAIT_LOCK: tmr_load = LD_LOCK;
      SETTLE:    tmr_load = LD_SETTLE;
      default:   tmr_load = '0;
    endcase
  end

  // Outputs are registered from state_d so they change with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_PLL;
      tmr_q   <= LD_RST;
      retry_q <= '0;
      pll_rst <= 1'b1;
      ready   <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (reload)         tmr_q <= tmr_load;
      else if (!tmr_zero) tmr_q <= tmr_q - 1'b1;
      if (req_reset || state_d == READY) retry_q <= '0;
      else if (timeout)                  retry_q <= retry_q + 1'b1;
      pll_rst <= (state_d == RESET_PLL) || (state_d == FAULT);
      ready   <= (state_d == READY);
      fault   <= (state_d == FAULT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unlock_cnt  <= '0;
      timeout_cnt <= '0;
    end else if (clr_counts) begin
      unlock_cnt  <= '0;
      timeout_cnt <= '0;
    end else begin
      if (unlock && unlock_cnt != '1)   unlock_cnt  <= unlock_cnt + 1'b1;
      if (timeout && timeout_cnt != '1) timeout_cnt <= timeout_cnt + 1'b1;
    end
  end

endmodule
